// File: rtl/scope_trace_renderer.sv
// Oscilloscope renderer: captures triggered ADC records into a double-buffered trace memory and
// draws the displayed record over a graticule with a 2-cycle pixel pipeline.
module scope_trace_renderer #(
  parameter int unsigned SAMPLE_W     = 8,
  parameter int unsigned REC_LEN      = 1024,
  parameter int unsigned AUTO_TIMEOUT = 65535
) (
  input  logic                vclock,
  input  logic                reset_n,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_falling,
  input  logic [11:0]         displayX,
  input  logic [11:0]         displayY,
  input  logic                hsync,
  input  logic                vsync,
  input  logic                blank,
  output logic [3:0]          vga_r,
  output logic [3:0]          vga_g,
  output logic [3:0]          vga_b,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                blank_out,
  output logic                armed,
  output logic                trace_valid
);

  localparam int unsigned AW = $clog2(REC_LEN);
  localparam int unsigned CW = $clog2(AUTO_TIMEOUT + 1);

  localparam logic [1:0] StArmed   = 2'd0;
  localparam logic [1:0] StCapture = 2'd1;
  localparam logic [1:0] StHold    = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d, wr_idx;
  logic [CW-1:0]       auto_q, auto_d;
  logic [SAMPLE_W-1:0] prev_q;
  logic                disp_bank_q, disp_bank_d;
  logic                trace_valid_q, trace_valid_d;
  logic                trig, wr_en, vsync_fall;

  // Stage-1 registers
  logic [11:0]         x1_q, y1_q;
  logic                hs1_q, vs1_q, bl1_q;
  logic [SAMPLE_W-1:0] rd_data;

  logic [SAMPLE_W-1:0] mem [2*REC_LEN];

  always_comb begin
    if (trig_falling) trig = (prev_q >= trig_level) && (sample_data < trig_level);
    else              trig = (prev_q < trig_level) && (sample_data >= trig_level);
  end

  // vs1_q is vsync delayed one cycle, shared with the render pipeline
  assign vsync_fall = vs1_q & ~vsync;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    auto_d        = auto_q;
    disp_bank_d   = disp_bank_q;
    trace_valid_d = trace_valid_q;
    wr_en         = 1'b0;
    wr_idx        = idx_q;
    unique case (state_q)
      StArmed: begin
        if (sample_valid) begin
          if (trig || (auto_q == CW'(AUTO_TIMEOUT - 1))) begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            idx_d   = AW'(1);
            auto_d  = '0;
            state_d = StCapture;
          end else begin
            auto_d = auto_q + 1'b1;
          end
        end
      end
      StCapture: begin
        if (sample_valid) begin
          wr_en = 1'b1;
          idx_d = idx_q + 1'b1;
          if (idx_q == AW'(REC_LEN - 1)) state_d = StHold;
        end
      end
      StHold: begin
        if (vsync_fall) begin
          disp_bank_d   = ~disp_bank_q;
          trace_valid_d = 1'b1;
          idx_d         = '0;
          state_d       = StArmed;
        end
      end
      default: state_d = StArmed;
    endcase
  end

  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StArmed;
      idx_q         <= '0;
      auto_q        <= '0;
      prev_q        <= '0;
      disp_bank_q   <= 1'b0;
      trace_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      auto_q        <= auto_d;
      disp_bank_q   <= disp_bank_d;
      trace_valid_q <= trace_valid_d;
      if (sample_valid) prev_q <= sample_data;
    end
  end

  // Write bank is always the complement of the display bank, so the ports never collide
  always_ff @(posedge vclock) begin
    if (wr_en) mem[{~disp_bank_q, wr_idx}] <= sample_data;
    rd_data <= mem[{disp_bank_q, displayX[AW-1:0]}];
  end

  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      x1_q  <= '0;
      y1_q  <= '0;
      hs1_q <= 1'b1;
      vs1_q <= 1'b1;
      bl1_q <= 1'b1;
    end else begin
      x1_q  <= displayX;
      y1_q  <= displayY;
      hs1_q <= hsync;
      vs1_q <= vsync;
      bl1_q <= blank;
    end
  end

  logic [9:0]  y_top;
  logic        on_trace, on_grid;
  logic [11:0] rgb_d;

  always_comb begin
    y_top    = 10'd765 - (10'(rd_data) * 10'd3);
    on_trace = ({2'b00, y_top} <= y1_q) && (y1_q <= ({2'b00, y_top} + 12'd2));
    on_grid  = (x1_q[6:0] == 7'd0) || ((y1_q % 12'd96) == 12'd0) ||
               (x1_q == 12'd1023) || (y1_q == 12'd767);
    rgb_d    = 12'h000;
    if (!bl1_q) begin
      if (trace_valid_q && on_trace) rgb_d = 12'h0F0;
      else if (on_grid)              rgb_d = 12'h444;
    end
  end

  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      blank_out <= 1'b1;
    end else begin
      vga_r     <= rgb_d[11:8];
      vga_g     <= rgb_d[7:4];
      vga_b     <= rgb_d[3:0];
      hsync_out <= hs1_q;
      vsync_out <= vs1_q;
      blank_out <= bl1_q;
    end
  end

  assign armed       = (state_q == StArmed);
  assign trace_valid = trace_valid_q;

endmodule

// File: tb/tb_scope_trace_renderer.sv
// Self-checking bench for scope_trace_renderer: directed capture/swap scenarios, a graticule
// vector table and a randomized run against a record-level reference model.
module tb_scope_trace_renderer;

  localparam int REC_LEN = 1024;
  localparam int AUTO    = 16;

  logic        vclock, reset_n;
  logic        sample_valid, trig_falling;
  logic [7:0]  sample_data, trig_level;
  logic [11:0] displayX, displayY;
  logic        hsync, vsync, blank;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync_out, vsync_out, blank_out, armed, trace_valid;

  scope_trace_renderer #(
    .SAMPLE_W    (8),
    .REC_LEN     (REC_LEN),
    .AUTO_TIMEOUT(AUTO)
  ) dut (
    .vclock      (vclock),
    .reset_n     (reset_n),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .trig_level  (trig_level),
    .trig_falling(trig_falling),
    .displayX    (displayX),
    .displayY    (displayY),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank       (blank),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .blank_out   (blank_out),
    .armed       (armed),
    .trace_valid (trace_valid)
  );

  initial vclock = 1'b0;
  always #5 vclock = ~vclock;

  int checks = 0;
  int errors = 0;

  // Reference model: record-level view of the scope
  int   phase;          // 0 waiting for trigger, 1 filling record, 2 record full
  int   auto_cnt, prev, tv, vs_prev;
  int   rec[$];
  int   shown[REC_LEN];
  int   p_rd, p_x, p_y, p_hs, p_vs, p_bl;
  logic [14:0] exp_out;
  bit   model_en = 1'b0;

  typedef struct {
    int          x;
    int          y;
    int          bl;
    logic [11:0] rgb;
  } px_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] exp_color(int rd, int x, int y, int bl, int t);
    int yt;
    yt = 765 - 3 * rd;
    if (bl != 0) return 12'h000;
    if (t != 0 && y >= yt && y <= yt + 2) return 12'h0F0;
    if (x % 128 == 0 || y % 96 == 0 || x == 1023 || y == 767) return 12'h444;
    return 12'h000;
  endfunction

  function automatic void model_reset();
    phase = 0; auto_cnt = 0; prev = 0; tv = 0; vs_prev = 1;
    rec.delete();
    p_rd = 0; p_x = 0; p_y = 0; p_hs = 1; p_vs = 1; p_bl = 1;
  endfunction

  function automatic void model_edge();
    int  start, d, lvl;
    bit  trig;
    start = phase;
    if (start == 2 && vs_prev == 1 && vsync == 1'b0) begin
      foreach (shown[i]) shown[i] = rec[i];
      rec.delete();
      tv    = 1;
      phase = 0;
    end
    if (sample_valid) begin
      d   = int'(sample_data);
      lvl = int'(trig_level);
      trig = trig_falling ? (prev >= lvl && d < lvl) : (prev < lvl && d >= lvl);
      if (start == 0) begin
        if (!trig) auto_cnt++;
        if (trig || auto_cnt == AUTO) begin
          rec.delete();
          rec.push_back(d);
          auto_cnt = 0;
          phase    = 1;
        end
      end else if (start == 1) begin
        rec.push_back(d);
        if (rec.size() == REC_LEN) phase = 2;
      end
      prev = d;
    end
    vs_prev = int'(vsync);
  endfunction

  task automatic tick();
    logic [11:0] c;
    @(posedge vclock);
    if (model_en) begin
      c       = exp_color(p_rd, p_x, p_y, p_bl, tv);
      exp_out = {c, p_hs[0], p_vs[0], p_bl[0]};
      p_rd = shown[int'(displayX) % REC_LEN];
      p_x  = int'(displayX); p_y = int'(displayY);
      p_hs = int'(hsync); p_vs = int'(vsync); p_bl = int'(blank);
      model_edge();
    end
    #1;
    if (model_en) begin
      check("pipe", {vga_r, vga_g, vga_b, hsync_out, vsync_out, blank_out}, exp_out);
      check("status", {armed, trace_valid}, {phase == 0, tv == 1});
    end
  endtask

  task automatic do_reset();
    model_en = 1'b0;
    @(posedge vclock);
    #2 reset_n = 1'b0;
    #1;
    check("rst_out", {vga_r, vga_g, vga_b, hsync_out, vsync_out, blank_out}, {12'h000, 3'b111});
    check("rst_status", {armed, trace_valid}, 2'b10);
    @(posedge vclock);
    @(negedge vclock);
    reset_n = 1'b1;
    model_reset();
    model_en = 1'b1;
  endtask

  task automatic feed(input int d);
    sample_valid = 1'b1;
    sample_data  = 8'(d);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic vsync_fall();
    vsync = 1'b1; tick();
    vsync = 1'b0; tick(); tick();
    vsync = 1'b1; tick();
  endtask

  task automatic check_px(input string name, input int x, input int y, input int bl,
                          input logic [11:0] exp);
    displayX = 12'(x); displayY = 12'(y); blank = 1'(bl);
    tick();
    displayX = '0; displayY = '0; blank = 1'b1;
    tick();
    check(name, {vga_r, vga_g, vga_b}, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    px_vec_t vecs[$];
    vecs = '{
      '{5, 765, 0, 12'h0F0}, '{5, 766, 0, 12'h0F0}, '{1000, 767, 0, 12'h0F0},
      '{5, 764, 0, 12'h000}, '{0, 10, 0, 12'h444}, '{128, 10, 0, 12'h444},
      '{896, 10, 0, 12'h444}, '{1023, 10, 0, 12'h444}, '{127, 10, 0, 12'h000},
      '{5, 0, 0, 12'h444}, '{5, 96, 0, 12'h444}, '{5, 672, 0, 12'h444},
      '{5, 673, 0, 12'h000}, '{0, 382, 0, 12'h444}, '{500, 500, 0, 12'h000},
      '{0, 0, 1, 12'h000}, '{1023, 767, 1, 12'h000}
    };

    reset_n = 1'b0; sample_valid = 1'b0; sample_data = '0;
    trig_level = 8'd128; trig_falling = 1'b0;
    displayX = '0; displayY = '0; hsync = 1'b1; vsync = 1'b1; blank = 1'b1;
    foreach (shown[i]) shown[i] = 0;
    model_reset();

    // Reset in the middle of a capture
    do_reset();
    tick();
    check("armed_after_rst", armed, 1);
    for (int v = 120; v < 129; v++) feed(v);
    check("capturing", armed, 0);
    for (int k = 1; k < 500; k++) feed((128 + k) % 256);
    do_reset();
    tick();
    check("mid_rst_armed", armed, 1);
    check("mid_rst_tv", trace_valid, 0);
    vsync_fall();
    check("no_swap", trace_valid, 0);

    // Rising ramp, level 128: record starts at 128
    for (int k = 0; k < 8 + REC_LEN; k++) feed((120 + k) % 256);
    feed(200);
    check("hold", armed, 0);
    check_px("pre_swap", 0, 382, 0, 12'h444);
    vsync_fall();
    check("tv_set", trace_valid, 1);
    check_px("c0_381", 0, 381, 0, 12'h0F0);
    check_px("c0_382", 0, 382, 0, 12'h0F0);
    check_px("c0_383", 0, 383, 0, 12'h0F0);
    check_px("c0_380", 0, 380, 0, 12'h444);
    check_px("c0_384", 0, 384, 0, 12'h444);
    check_px("c1_378", 1, 378, 0, 12'h0F0);
    check_px("c1_380", 1, 380, 0, 12'h0F0);
    check_px("c1_381", 1, 381, 0, 12'h000);
    check_px("c1_377", 1, 377, 0, 12'h000);

    // Constant 0 record completing on the same cycle as a vsync fall: swap waits a frame
    for (int k = 0; k < AUTO - 1 + REC_LEN - 1; k++) feed(0);
    vsync = 1'b0;
    feed(0);
    tick(); tick();
    check("held", armed, 0);
    check_px("old_trace", 0, 382, 0, 12'h0F0);
    check_px("no_new", 5, 766, 0, 12'h000);
    vsync = 1'b1; tick();
    vsync = 1'b0; tick();
    vsync = 1'b1; tick();
    check("swapped", armed, 1);
    for (int i = 0; i < vecs.size(); i++)
      check_px($sformatf("grid%0d", i), vecs[i].x, vecs[i].y, vecs[i].bl, vecs[i].rgb);

    // Falling trigger on a rising ramp never fires; auto capture after AUTO strobes
    do_reset();
    trig_falling = 1'b1;
    for (int v = 0; v < AUTO - 1; v++) feed(v);
    check("auto_wait", armed, 1);
    feed(AUTO - 1);
    check("auto_fire", armed, 0);
    for (int k = 0; k < REC_LEN - 1; k++) feed((AUTO + k) % 256);
    vsync_fall();
    check("auto_tv", trace_valid, 1);
    check_px("a0_721", 0, 721, 0, 12'h0F0);
    check_px("a0_723", 0, 723, 0, 12'h444);
    check_px("a1_718", 1, 718, 0, 12'h0F0);
    check_px("a1_716", 1, 716, 0, 12'h000);

    // Random timing and samples against the model
    trig_level   = 8'($urandom_range(0, 255));
    trig_falling = 1'($urandom_range(0, 1));
    for (int n = 0; n < 6000; n++) begin
      sample_valid = 1'($urandom_range(0, 1));
      sample_data  = 8'($urandom_range(0, 255));
      displayX     = 12'($urandom_range(0, 1100));
      displayY     = 12'($urandom_range(0, 800));
      blank        = (displayX >= 12'd1024) ? 1'b1 : 1'($urandom_range(0, 1));
      hsync        = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 4) vsync = ~vsync;
      tick();
    end
    sample_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scope_trace_renderer.md
Name: scope_trace_renderer

Overview:
- Consumes the 1024x768 timing stream (displayX, displayY, hsync, vsync, blank) from the XVGA timing generator.
- Produces the RGB pixel stream for the oscilloscope screen.
- Captures triggered ADC sample records into a double-buffered trace memory, one sample per column.
- Banks swap only at a frame boundary so the trace never tears. Draws the trace over a fixed graticule, re-aligning sync/blank to the renderer latency.

Parameters:
- SAMPLE_W, 8, ADC sample width (fixed at 8 for the y-scaling rule below)
- REC_LEN, 1024, samples per record, equal to visible columns
- AUTO_TIMEOUT, 65535, sample_valid strobes without a trigger before a forced (auto) capture

Ports:
- vclock  in  1  pixel clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- sample_valid  in  1  one-cycle strobe, ADC sample present
- sample_data  in  8  unsigned ADC sample
- trig_level  in  8  trigger threshold
- trig_falling  in  1  0 = rising-edge trigger, 1 = falling-edge trigger
- displayX  in  12  pixel column from timing generator
- displayY  in  12  line number from timing generator
- hsync, vsync  in  1 each  active-low syncs from timing generator
- blank  in  1  high outside visible area
- vga_r, vga_g, vga_b  out  4 each  pixel colour
- hsync_out, vsync_out, blank_out  out  1 each  syncs delayed to match pixel latency
- armed  out  1  capture FSM in ARMED
- trace_valid  out  1  a completed record is displayed

Behaviour:
- Reset (async, reset_n low):
  - vga_r/g/b = 0; hsync_out = 1, vsync_out = 1, blank_out = 1.
  - FSM -> ARMED; write bank = 1, display bank = 0; trace_valid = 0; write index = 0; auto counter = 0; prev_sample = 0.
  - armed is 1 on the first cycle after release.
- Trigger:
  - Rising: prev_sample < trig_level && sample_data >= trig_level.
  - Falling: prev_sample >= trig_level && sample_data < trig_level.
  - Evaluated only on sample_valid. prev_sample updates on every sample_valid, in every state.
- Capture FSM:
  - ARMED: on a trigger sample, write that sample at index 0, set index = 1, go to CAPTURE. Otherwise increment the auto counter; when it reaches AUTO_TIMEOUT, treat the current sample as the trigger (same action). Auto counter clears on entering CAPTURE.
  - CAPTURE: each sample_valid writes sample_data to the write bank at index, then index += 1. The write at index REC_LEN-1 moves the FSM to HOLD. Non-valid cycles write nothing.
  - HOLD: ignore samples except for the prev_sample update. On the vsync falling edge (registered vsync 1, current vsync 0): swap banks, set trace_valid = 1, index = 0, go to ARMED.
  - If the record completes on the same cycle as a vsync falling edge, the swap waits for the next vsync falling edge; no swap occurs within the same cycle as entry to HOLD.
  - Display reads never touch the write bank.
- Render pipeline, latency 2 cycles:
  - Stage 1: read display bank at address displayX[9:0]; register displayX, displayY, hsync, vsync, blank.
  - Stage 2: compute colour; register outputs. hsync_out/vsync_out/blank_out equal the inputs delayed exactly 2 cycles.
- Y scaling: y_top = 765 - 3*sample (10-bit unsigned, range 0..765). Trace pixel when y_top <= displayY <= y_top+2 (3 lines thick).
- Colour priority, stage 2:
  1. Delayed blank = 1: RGB = 0.
  2. trace_valid && trace pixel: R=0, G=F, B=0.
  3. Graticule (displayX[6:0]==0 or displayY%96==0 or displayX==1023 or displayY==767): R=4, G=4, B=4.
  4. Otherwise 0.
- displayX >= 1024 is always blanked by the timing source. The renderer does not range-check beyond the blank input.
- Trace memory: 2 x 1024 x 8, one synchronous write port and one synchronous read port. Block-RAM inferable.

Test Plan:
- Reset mid-CAPTURE (after 500 samples) -> armed = 1 next cycle, trace_valid = 0, outputs RGB 0 with syncs high during reset; no bank swap occurs.
- Ramp 0..255 repeating, trig_level = 128, rising -> first record sample 0 = 128; after the next vsync fall, column 0 green on lines 381..383, column 1 on lines 378..380.
- trig_falling = 1, same ramp (wrap 255->0 is the only falling crossing at level 128? no) -> no trigger; after AUTO_TIMEOUT = 16 strobes a capture starts, and the trace appears after the next frame.
- Record completes mid-frame -> displayed pixels keep the old trace until the vsync falling edge; the new trace appears from the following frame's line 0, with no mixed frame.
- Constant sample 0, trace_valid = 1 -> green on lines 765..767 at every column; graticule grey at x=0,128,...,896,1023 and y=0,96,...,672,767 elsewhere; blank region RGB 0.
- Random timing inputs -> hsync_out/vsync_out/blank_out match inputs delayed exactly 2 cycles on every cycle.
